traffic_ctrl_param: RTL

Parametrised successor to the fixed-timing intersection controller. It sequences main-road, side-road and pedestrian phases. Per-phase durations and the clock-to-second prescaler are parameters. It also adds a phase/time-remaining status output and an optional all-red clearance interval. The block sits between the board I/O (buttons and sensor, already debounced) and the lamp drivers.

---
 rtl/traffic_ctrl_param.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/traffic_ctrl_param.sv
// Intersection controller: main/side/walk phases, parameterised durations and prescaler.
// Define TRAFFIC_ALLRED_EN to add an all-red clearance interval after every yellow.
module traffic_ctrl_param #(
  parameter int TICK_DIV      = 50000000,
  parameter int TW            = 4,
  parameter int MAIN_GREEN    = 6,
  parameter int MAIN_EXT_BUSY = 3,
  parameter int MAIN_EXT_IDLE = 6,
  parameter int SIDE_GREEN    = 6,
  parameter int SIDE_EXT      = 3,
  parameter int YELLOW        = 2,
  parameter int WALK          = 3,
  parameter int ALLRED        = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          walkRequest,
  input  logic          trafficSensor,
  output logic [2:0]    mainLights,
  output logic [2:0]    sideLights,
  output logic          walkLamp,
  output logic          walkPending,
  output logic [2:0]    phase,
  output logic [TW-1:0] timeLeft
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    P_MAIN = 3'd0, P_MAIN_EXT = 3'd1, P_MAIN_YEL = 3'd2, P_SIDE = 3'd3,
    P_SIDE_EXT = 3'd4, P_SIDE_YEL = 3'd5, P_WALK = 3'd6, P_ALL_RED = 3'd7
  } phase_e;

  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;

  phase_e        phase_q, phase_d;
  logic [TW-1:0] time_q, time_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          walk_q, walk_d;
  logic          tick, enter_walk;

`ifdef TRAFFIC_ALLRED_EN
  localparam logic [1:0] T_MAIN = 2'd0, T_SIDE = 2'd1, T_WALK = 2'd2;
  logic [1:0] target_q, target_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) target_q <= T_MAIN;
    else      target_q <= target_d;
  end
`endif

  assign tick = (cnt_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= P_SIDE_YEL;
      time_q  <= TW'(1);
      cnt_q   <= '0;
      walk_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      time_q  <= time_d;
      cnt_q   <= cnt_d;
      walk_q  <= walk_d;
    end
  end

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    phase_d = phase_q;
    time_d  = time_q;
`ifdef TRAFFIC_ALLRED_EN
    target_d = target_q;
`endif
    if (tick) begin
      if (time_q > TW'(1)) begin
        time_d = time_q - 1'b1;
      end else begin
        case (phase_q)
          P_MAIN: begin
            phase_d = P_MAIN_EXT;
            time_d  = trafficSensor ? TW'(MAIN_EXT_BUSY) : TW'(MAIN_EXT_IDLE);
          end
          P_MAIN_EXT: begin phase_d = P_MAIN_YEL; time_d = TW'(YELLOW); end
`ifdef TRAFFIC_ALLRED_EN
          P_MAIN_YEL: begin
            phase_d  = P_ALL_RED;
            time_d   = TW'(ALLRED);
            target_d = walk_q ? T_WALK : T_SIDE;
          end
          P_SIDE_YEL: begin
            phase_d  = P_ALL_RED;
            time_d   = TW'(ALLRED);
            target_d = T_MAIN;
          end
          P_ALL_RED: begin
            case (target_q)
              T_WALK:  begin phase_d = P_WALK; time_d = TW'(WALK);       end
              T_SIDE:  begin phase_d = P_SIDE; time_d = TW'(SIDE_GREEN); end
              default: begin phase_d = P_MAIN; time_d = TW'(MAIN_GREEN); end
            endcase
          end
`else
          P_MAIN_YEL: begin
            if (walk_q) begin phase_d = P_WALK; time_d = TW'(WALK);       end
            else        begin phase_d = P_SIDE; time_d = TW'(SIDE_GREEN); end
          end
          P_SIDE_YEL: begin phase_d = P_MAIN; time_d = TW'(MAIN_GREEN); end
          // ALL_RED is not a legal phase here; recover through a yellow.
          P_ALL_RED:  begin phase_d = P_MAIN_YEL; time_d = TW'(YELLOW); end
`endif
          P_SIDE: begin
            if (trafficSensor) begin phase_d = P_SIDE_EXT; time_d = TW'(SIDE_EXT); end
            else               begin phase_d = P_SIDE_YEL; time_d = TW'(YELLOW);   end
          end
          P_SIDE_EXT: begin phase_d = P_SIDE_YEL; time_d = TW'(YELLOW);     end
          P_WALK:     begin phase_d = P_SIDE;     time_d = TW'(SIDE_GREEN); end
          default:    begin phase_d = P_MAIN_YEL; time_d = TW'(YELLOW);     end
        endcase
      end
    end
    // A request on the entry edge wins over the clear, so it is kept for next round.
    enter_walk = (phase_d == P_WALK) && (phase_q != P_WALK);
    walk_d     = walkRequest | (walk_q & ~enter_walk);
  end

  always_comb begin
    mainLights = RED;
    sideLights = RED;
    walkLamp   = 1'b0;
    case (phase_q)
      P_MAIN, P_MAIN_EXT: mainLights = GRN;
      P_MAIN_YEL:         mainLights = YEL;
      P_SIDE, P_SIDE_EXT: sideLights = GRN;
      P_SIDE_YEL:         sideLights = YEL;
      P_WALK:             walkLamp   = 1'b1;
      default: ;
    endcase
  end

  assign phase       = phase_q;
  assign timeLeft    = time_q;
  assign walkPending = walk_q;

endmodule
